// File: rtl/line_buffer_ctrl.sv
// Write/read controller for a bank of line buffers forming a sliding WIN-row pixel window.
// Writes whole lines round-robin; reads WIN buffers in parallel and registers an oldest-row-first window.
module line_buffer_ctrl #(
    parameter int unsigned LINE_W  = 480,
    parameter int unsigned NUM_BUF = 7,
    parameter int unsigned WIN     = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_pixel,
    input  logic                     i_pixel_valid,
    output logic [7:0]               o_lb_data,
    output logic [NUM_BUF-1:0]       o_lb_wr_en,
    output logic [NUM_BUF-1:0]       o_lb_rd_en,
    input  logic [NUM_BUF*WIN*8-1:0] i_lb_rows,
    input  logic                     i_window_ready,
    output logic [WIN*WIN*8-1:0]     o_window,
    output logic                     o_window_valid,
    output logic                     o_line_done,
    output logic                     o_overflow
);

    localparam int unsigned CNT_W     = $clog2(LINE_W);
    localparam int unsigned SEL_W     = $clog2(NUM_BUF);
    localparam int unsigned FULL_LVL  = NUM_BUF * LINE_W;
    localparam int unsigned READY_LVL = WIN * LINE_W;
    localparam int unsigned FILL_W    = $clog2(FULL_LVL + 1);
    localparam int unsigned ROW_W     = WIN * 8;
    localparam int unsigned LAST_VLD  = LINE_W - WIN;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [CNT_W-1:0]     wr_cnt;
    logic [SEL_W-1:0]     wr_sel;
    logic [CNT_W-1:0]     rd_cnt;
    logic [SEL_W-1:0]     rd_sel;
    logic [FILL_W-1:0]    fill_cnt;
    logic [FILL_W-1:0]    fill_nxt;
    logic [WIN*WIN*8-1:0] win_nxt;
    logic                 full;
    logic                 accept;
    logic                 strobe;
    logic                 last_wr;
    logic                 last_rd;

    // Buffer index sel+off modulo NUM_BUF; off is always below NUM_BUF.
    function automatic logic [SEL_W-1:0] sel_add(input logic [SEL_W-1:0] sel, input int unsigned off);
        int unsigned sum;
        sum = 32'(sel) + off;
        if (sum >= NUM_BUF) begin
            sum = sum - NUM_BUF;
        end
        return SEL_W'(sum);
    endfunction

    assign full      = (fill_cnt == FILL_W'(FULL_LVL));
    assign accept    = i_pixel_valid && !full;
    assign strobe    = (state == ST_READ) && i_window_ready;
    assign last_wr   = (wr_cnt == CNT_W'(LINE_W - 1));
    assign last_rd   = (rd_cnt == CNT_W'(LINE_W - 1));
    assign o_lb_data = i_pixel;

    // Next state, fill level, buffer strobes and the window gathered oldest row first.
    always_comb begin
        state_nxt  = state;
        fill_nxt   = fill_cnt;
        o_lb_wr_en = '0;
        o_lb_rd_en = '0;
        win_nxt    = '0;

        if (accept) begin
            o_lb_wr_en = NUM_BUF'(1) << wr_sel;
        end

        case ({accept, strobe})
            2'b10:   fill_nxt = fill_cnt + FILL_W'(1);
            2'b01:   fill_nxt = fill_cnt - FILL_W'(1);
            default: fill_nxt = fill_cnt;
        endcase

        for (int unsigned r = 0; r < WIN; r++) begin
            win_nxt[r*ROW_W +: ROW_W] = i_lb_rows[32'(sel_add(rd_sel, r))*ROW_W +: ROW_W];
            if (strobe) begin
                o_lb_rd_en[sel_add(rd_sel, r)] = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (fill_cnt >= FILL_W'(READY_LVL)) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                // Only a line boundary may drop back to idle, judged on the updated fill level.
                if (strobe && last_rd && (fill_nxt < FILL_W'(READY_LVL))) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            wr_cnt         <= '0;
            wr_sel         <= '0;
            rd_cnt         <= '0;
            rd_sel         <= '0;
            fill_cnt       <= '0;
            o_window       <= '0;
            o_window_valid <= 1'b0;
            o_line_done    <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            state       <= state_nxt;
            fill_cnt    <= fill_nxt;
            o_line_done <= strobe && last_rd;

            if (i_pixel_valid && full) begin
                o_overflow <= 1'b1;
            end

            if (accept) begin
                wr_cnt <= last_wr ? '0 : wr_cnt + CNT_W'(1);
                if (last_wr) begin
                    wr_sel <= sel_add(wr_sel, 1);
                end
            end

            // The trailing strobes of a line only realign the read pointers.
            if (strobe) begin
                rd_cnt         <= last_rd ? '0 : rd_cnt + CNT_W'(1);
                o_window       <= win_nxt;
                o_window_valid <= (rd_cnt <= CNT_W'(LAST_VLD));
                if (last_rd) begin
                    rd_sel <= sel_add(rd_sel, 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: behavioural line buffer bank, directed vectors and
// streaming sequences with a per-cycle scoreboard.
module tb_line_buffer_ctrl;

    localparam int LINE_W  = 480;
    localparam int NUM_BUF = 7;
    localparam int WIN     = 6;
    localparam int ROW_W   = WIN * 8;
    localparam int VALID_PER_LINE = LINE_W - WIN + 1;

    typedef logic [287:0] val_t;

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] px;
        logic       rdy;
        logic [6:0] wr;
        logic [6:0] rd;
        logic       wv;
        logic       ovf;
    } vec_t;

    logic                     i_clk;
    logic                     i_rst;
    logic [7:0]               i_pixel;
    logic                     i_pixel_valid;
    logic [7:0]               o_lb_data;
    logic [NUM_BUF-1:0]       o_lb_wr_en;
    logic [NUM_BUF-1:0]       o_lb_rd_en;
    logic [NUM_BUF*WIN*8-1:0] i_lb_rows;
    logic                     i_window_ready;
    logic [WIN*WIN*8-1:0]     o_window;
    logic                     o_window_valid;
    logic                     o_line_done;
    logic                     o_overflow;

    line_buffer_ctrl #(.LINE_W(LINE_W), .NUM_BUF(NUM_BUF), .WIN(WIN)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pixel        (i_pixel),
        .i_pixel_valid  (i_pixel_valid),
        .o_lb_data      (o_lb_data),
        .o_lb_wr_en     (o_lb_wr_en),
        .o_lb_rd_en     (o_lb_rd_en),
        .i_lb_rows      (i_lb_rows),
        .i_window_ready (i_window_ready),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_line_done    (o_line_done),
        .o_overflow     (o_overflow)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Line buffer bank: write pointer per buffer, read pointer advanced by rd_en, 6-pixel tap.
    logic [7:0] mem [NUM_BUF][LINE_W];
    int wp [NUM_BUF];
    int rp [NUM_BUF];

    always @(posedge i_clk) begin
        for (int k = 0; k < NUM_BUF; k++) begin
            if (i_rst) begin
                wp[k] <= 0;
                rp[k] <= 0;
            end else begin
                if (o_lb_wr_en[k]) begin
                    mem[k][wp[k]] <= o_lb_data;
                    wp[k] <= (wp[k] + 1) % LINE_W;
                end
                if (o_lb_rd_en[k]) begin
                    rp[k] <= (rp[k] + 1) % LINE_W;
                end
            end
        end
    end

    always_comb begin
        i_lb_rows = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            for (int j = 0; j < WIN; j++) begin
                i_lb_rows[k*ROW_W + j*8 +: 8] = mem[k][(rp[k] + j) % LINE_W];
            end
        end
    end

    int   checks;
    int   errors;
    int   pix_idx;
    int   s;
    int   last_s;
    int   n_win;
    int   ld_cnt;
    logic exp_wv;
    logic pend_ld;
    logic started;
    logic mon_en;
    vec_t vecs [6];

    function automatic logic [7:0] pix_val(input int p);
        return 8'(((p / LINE_W) * 16 + (p % LINE_W)) & 255);
    endfunction

    function automatic logic [6:0] exp_wr(input int p);
        logic [6:0] m;
        m = '0;
        m[(p / LINE_W) % NUM_BUF] = 1'b1;
        return m;
    endfunction

    function automatic logic [6:0] rd_mask(input int sidx);
        logic [6:0] m;
        m = '0;
        for (int r = 0; r < WIN; r++) begin
            m[((sidx / LINE_W) + r) % NUM_BUF] = 1'b1;
        end
        return m;
    endfunction

    // Window produced by strobe number sidx: rows are lines L..L+5 starting at column c.
    function automatic val_t exp_win(input int sidx);
        val_t w;
        int l;
        int c;
        w = '0;
        l = sidx / LINE_W;
        c = sidx % LINE_W;
        for (int r = 0; r < WIN; r++) begin
            for (int j = 0; j < WIN; j++) begin
                w[r*ROW_W + j*8 +: 8] = 8'(((l + r) * 16 + c + j) & 255);
            end
        end
        return w;
    endfunction

    task automatic chk(input string nm, input val_t act, input val_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_mon();
        pix_idx = 0;
        s       = 0;
        last_s  = 0;
        n_win   = 0;
        ld_cnt  = 0;
        exp_wv  = 1'b0;
        pend_ld = 1'b0;
        started = 1'b0;
    endtask

    // Per-cycle scoreboard, called at the falling edge.
    task automatic monitor();
        logic strobe;
        chk("line_done", val_t'(o_line_done), val_t'(pend_ld));
        chk("win_valid", val_t'(o_window_valid), val_t'(exp_wv));
        if (exp_wv) chk("window", val_t'(o_window), exp_win(last_s));
        if (o_line_done) ld_cnt++;
        if (o_window_valid && i_window_ready) n_win++;
        if (i_pixel_valid) chk("wr_en", val_t'(o_lb_wr_en), val_t'(exp_wr(pix_idx)));
        strobe = (o_lb_rd_en != '0);
        if (!i_window_ready) chk("rd_stall", val_t'(o_lb_rd_en), val_t'(0));
        else if (started) chk("rd_nobubble", val_t'(strobe), val_t'(1));
        pend_ld = 1'b0;
        if (strobe && i_window_ready) begin
            chk("rd_en", val_t'(o_lb_rd_en), val_t'(rd_mask(s)));
            exp_wv  = ((s % LINE_W) <= LINE_W - WIN);
            last_s  = s;
            s++;
            started = 1'b1;
            pend_ld = ((s % LINE_W) == 0);
        end
    endtask

    task automatic drive(input logic v, input logic rdy);
        i_pixel_valid  = v;
        i_window_ready = rdy;
        i_pixel        = pix_val(pix_idx);
    endtask

    task automatic at_neg();
        @(negedge i_clk);
        if (mon_en) monitor();
    endtask

    task automatic to_pos();
        @(posedge i_clk);
        if (i_pixel_valid) pix_idx++;
        #1;
    endtask

    task automatic cycle(input logic v, input logic rdy);
        drive(v, rdy);
        at_neg();
        to_pos();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        i_rst  = 1'b1;
        drive(1'b0, 1'b1);
        to_pos();
        to_pos();
        i_rst = 1'b0;
        reset_mon();
        mon_en = 1'b1;
    endtask

    task automatic first_window();
        for (int i = 0; i < WIN * LINE_W; i++) cycle(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        at_neg();
        chk("fw_idle_rd", val_t'(o_lb_rd_en), val_t'(0));
        chk("fw_idle_valid", val_t'(o_window_valid), val_t'(0));
        to_pos();
        drive(1'b1, 1'b1);
        at_neg();
        chk("fw_first_strobe", val_t'(o_lb_rd_en), val_t'(7'h3F));
        chk("fw_not_yet_valid", val_t'(o_window_valid), val_t'(0));
        to_pos();
        drive(1'b1, 1'b1);
        at_neg();
        chk("fw_valid", val_t'(o_window_valid), val_t'(1));
        chk("fw_window", val_t'(o_window), exp_win(0));
        to_pos();
    endtask

    initial begin
        int   guard;
        logic t;
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        reset_mon();
        i_rst = 1'b1;
        drive(1'b0, 1'b0);

        vecs[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'h3C, 1'b1, 7'h01, 7'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 8'h77, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 8'h01, 1'b0, 7'h01, 7'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'hFF, 1'b1, 7'h00, 7'h00, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h5A, 1'b1, 7'h01, 7'h00, 1'b0, 1'b0};

        to_pos();
        to_pos();

        // Directed vectors around reset and the first accepted pixels.
        for (int i = 0; i < 6; i++) begin
            i_rst          = vecs[i].rst;
            i_pixel_valid  = vecs[i].v;
            i_pixel        = vecs[i].px;
            i_window_ready = vecs[i].rdy;
            @(negedge i_clk);
            chk($sformatf("vec%0d_wr", i), val_t'(o_lb_wr_en), val_t'(vecs[i].wr));
            chk($sformatf("vec%0d_rd", i), val_t'(o_lb_rd_en), val_t'(vecs[i].rd));
            chk($sformatf("vec%0d_data", i), val_t'(o_lb_data), val_t'(vecs[i].px));
            chk($sformatf("vec%0d_wv", i), val_t'(o_window_valid), val_t'(vecs[i].wv));
            chk($sformatf("vec%0d_ovf", i), val_t'(o_overflow), val_t'(vecs[i].ovf));
            to_pos();
        end
        i_rst = 1'b0;

        // First window, then eight lines of back-to-back reads covering the rd_sel wrap.
        do_reset();
        first_window();
        guard = 0;
        while (s < 8 * LINE_W && guard < 20000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        chk("t1_strobes", val_t'(s), val_t'(8 * LINE_W));
        chk("t1_windows", val_t'(n_win), val_t'(8 * VALID_PER_LINE));
        cycle(1'b0, 1'b0);
        chk("t1_line_done", val_t'(ld_cnt), val_t'(8));

        // Reset at rd_cnt = 200, then a fresh fill.
        do_reset();
        first_window();
        guard = 0;
        while (s < 200 && guard < 1000) begin
            cycle(1'b1, 1'b1);
            guard++;
        end
        chk("t2_reached_200", val_t'(s), val_t'(200));
        mon_en = 1'b0;
        i_rst  = 1'b1;
        drive(1'b0, 1'b1);
        to_pos();
        i_rst = 1'b0;
        reset_mon();
        drive(1'b0, 1'b1);
        @(negedge i_clk);
        chk("rst_window", val_t'(o_window), val_t'(0));
        chk("rst_valid", val_t'(o_window_valid), val_t'(0));
        chk("rst_line_done", val_t'(o_line_done), val_t'(0));
        chk("rst_ovf", val_t'(o_overflow), val_t'(0));
        chk("rst_rd_idle", val_t'(o_lb_rd_en), val_t'(0));
        chk("rst_wr", val_t'(o_lb_wr_en), val_t'(0));
        to_pos();
        mon_en = 1'b1;
        first_window();

        // Backpressure: ready and input toggle together for two lines.
        do_reset();
        first_window();
        t = 1'b0;
        guard = 0;
        while (s < 2 * LINE_W && guard < 5000) begin
            cycle(t, t);
            t = ~t;
            guard++;
        end
        chk("t3_strobes", val_t'(s), val_t'(2 * LINE_W));
        chk("t3_windows", val_t'(n_win), val_t'(2 * VALID_PER_LINE));
        cycle(1'b0, 1'b0);
        chk("t3_line_done", val_t'(ld_cnt), val_t'(2));

        // Overflow: ready held low until the bank is full.
        do_reset();
        mon_en = 1'b0;
        for (int i = 0; i < NUM_BUF * LINE_W - 1; i++) cycle(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        at_neg();
        chk("ovf_last_wr", val_t'(o_lb_wr_en), val_t'(7'h40));
        to_pos();
        drive(1'b1, 1'b0);
        at_neg();
        chk("ovf_drop_wr", val_t'(o_lb_wr_en), val_t'(0));
        chk("ovf_not_yet", val_t'(o_overflow), val_t'(0));
        to_pos();
        drive(1'b1, 1'b0);
        at_neg();
        chk("ovf_set", val_t'(o_overflow), val_t'(1));
        chk("ovf_still_full", val_t'(o_lb_wr_en), val_t'(0));
        chk("ovf_no_window", val_t'(o_window_valid), val_t'(0));
        to_pos();
        drive(1'b1, 1'b1);
        at_neg();
        chk("ovf_strobe", val_t'(o_lb_rd_en), val_t'(7'h3F));
        chk("ovf_full_same_cycle", val_t'(o_lb_wr_en), val_t'(0));
        to_pos();
        drive(1'b1, 1'b0);
        at_neg();
        chk("ovf_accept_after_strobe", val_t'(o_lb_wr_en), val_t'(7'h01));
        chk("ovf_window_valid", val_t'(o_window_valid), val_t'(1));
        chk("ovf_window", val_t'(o_window), exp_win(0));
        chk("ovf_sticky", val_t'(o_overflow), val_t'(1));
        to_pos();
        drive(1'b1, 1'b0);
        at_neg();
        chk("ovf_refull", val_t'(o_lb_wr_en), val_t'(0));
        to_pos();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
